// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised full-duplex SPI master, all CPOL/CPHA modes, one word per transfer
// Defining SPI_MSB_FIRST_EN adds a msb_first input selecting MSB-first bit order per transfer.
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 3,
  parameter int CLK_DIV = 1,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_MSB_FIRST_EN
  input  logic              msb_first,
`endif
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt;
  logic [HALF_W-1:0]  half_cnt;
  logic [DATA_W-1:0]  tx_sh;
  logic [DATA_W-1:0]  rx_sh;
  logic               cpol_q;
  logic               cpha_q;
  logic               msb_q;

  logic               msb_in;
  logic               div_end;
  logic               half_last;
  logic               sample_edge;
  logic               shift_edge;
  logic [NUM_CS-1:0]  cs_dec;
  logic [DATA_W-1:0]  tx_ord;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
    return r;
  endfunction

`ifdef SPI_MSB_FIRST_EN
  assign msb_in = msb_first;
`else
  assign msb_in = 1'b0;
`endif

  assign busy = (state_q != IDLE);

  // MSB-first is handled by reversing the word at load and unload, so the shifters stay LSB-first.
  always_comb begin
    tx_ord = tx_data;
    if (msb_in) tx_ord = bit_rev(tx_data);
  end

  // Out-of-range selects leave every line deasserted.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(cs_sel) == i) cs_dec[i] = 1'b0;
    end
  end

  always_comb begin
    div_end     = (div_cnt == DIV_LAST);
    half_last   = (half_cnt == HALF_LAST);
    sample_edge = (state_q == XFER) && div_end && (half_cnt[0] == cpha_q);
    shift_edge  = (state_q == XFER) && div_end && (half_cnt[0] != cpha_q) && !half_last;
    state_d     = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (div_end) state_d = XFER;
      XFER:    if (div_end && half_last) state_d = HOLD;
      HOLD:    if (div_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      done     <= 1'b0;
      rx_data  <= '0;
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      msb_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk     <= cpol;
          div_cnt  <= '0;
          half_cnt <= '0;
          if (start) begin
            cpol_q <= cpol;
            cpha_q <= cpha;
            msb_q  <= msb_in;
            cs_n   <= cs_dec;
            rx_sh  <= '0;
            // With cpha=0 the first bit must be on the wire before the first (sampling) edge.
            if (cpha) begin
              tx_sh <= tx_ord;
            end else begin
              mosi  <= tx_ord[0];
              tx_sh <= tx_ord >> 1;
            end
          end
        end
        SETUP: begin
          div_cnt <= div_end ? '0 : div_cnt + 1'b1;
        end
        XFER: begin
          if (div_end) begin
            div_cnt  <= '0;
            sclk     <= ~sclk;
            half_cnt <= half_last ? '0 : half_cnt + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if (sample_edge) rx_sh <= {miso, rx_sh[DATA_W-1:1]};
          if (shift_edge) begin
            mosi  <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
          end
        end
        HOLD: begin
          sclk <= cpol_q;
          if (div_end) begin
            div_cnt <= '0;
            cs_n    <= '1;
            done    <= 1'b1;
            rx_data <= msb_q ? bit_rev(rx_sh) : rx_sh;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
